m_digest_serializer: RTL and testbench

Output-side counterpart of the input padder/parser: collects the eight 32-bit words of a finished SHA-256 digest (H0..H7) from the hashing core, buffers them, and serializes them as 32 bytes (optionally plus a terminator byte) to the UART transmitter over a start/busy byte handshake. It sits between the iterative compression core and the UART TX. Byte order is the mirror of the input parser: the first byte out is bits [31:24] of H0.

---
 rtl/m_digest_serializer.sv | 159 +++++++++++++++
 tb/tb_m_digest_serializer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_digest_serializer.sv
// m_digest_serializer
//
// Collects the eight 32-bit words of a finished SHA-256 digest (H0 first),
// buffers them, and sends them to a UART transmitter as 32 bytes, most
// significant byte of H0 first. An optional terminator byte can follow.
//
// Parameters:
//   SEND_TERM   - 1: append TERM_BYTE after the 32 digest bytes.
//   TERM_BYTE   - value of the terminator byte.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   word_in      in   digest word, H0 first
//   word_vld     in   word_in valid; accepted when word_rdy is also high
//   word_rdy     out  high while collecting words
//   tx_busy      in   UART TX is shifting a byte
//   tx_start     out  one-cycle byte request; tx_data valid while high
//   tx_data      out  byte to transmit
//   digest_sent  out  one-cycle pulse after the final byte completes
//   load_err     out  sticky; a word was offered while word_rdy was low
module m_digest_serializer #(
  parameter bit         SEND_TERM = 1'b1,
  parameter logic [7:0] TERM_BYTE = 8'h0A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_vld,
  output logic        word_rdy,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        digest_sent,
  output logic        load_err
);

  typedef enum logic [2:0] {
    StLoad,
    StSend,
    StWaitAck,
    StWaitIdle,
    StDone
  } state_e;

  // Index of the final byte: the terminator sits at index 32.
  localparam logic [5:0] LastIdx = SEND_TERM ? 6'd32 : 6'd31;

  state_e      state_q;
  logic [2:0]  wcnt_q;
  logic [5:0]  bidx_q;
  logic [31:0] word_buf_q [8];

  logic        word_accept;
  logic [31:0] sel_word;
  logic [7:0]  sel_byte;

  // word_rdy is high exactly while in StLoad, so this also gates buffer writes
  // to the load phase.
  assign word_accept = word_vld & word_rdy;

  // Word buffer has no reset; its contents only matter after a full load.
  always_ff @(posedge clk) begin
    if (word_accept) begin
      word_buf_q[wcnt_q] <= word_in;
    end
  end

  // Byte selection: big-endian within each word, terminator past the digest.
  always_comb begin
    sel_word = word_buf_q[bidx_q[4:2]];
    sel_byte = 8'h00;
    unique case (bidx_q[1:0])
      2'd0: sel_byte = sel_word[31:24];
      2'd1: sel_byte = sel_word[23:16];
      2'd2: sel_byte = sel_word[15:8];
      2'd3: sel_byte = sel_word[7:0];
    endcase
    if (bidx_q[5]) begin
      sel_byte = TERM_BYTE;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StLoad;
      wcnt_q      <= 3'd0;
      bidx_q      <= 6'd0;
      word_rdy    <= 1'b1;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      digest_sent <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      digest_sent <= 1'b0;

      if (word_vld && !word_rdy) begin
        load_err <= 1'b1;
      end

      case (state_q)
        StLoad: begin
          if (word_accept) begin
            if (wcnt_q == 3'd7) begin
              wcnt_q   <= 3'd0;
              bidx_q   <= 6'd0;
              word_rdy <= 1'b0;
              state_q  <= StSend;
            end else begin
              wcnt_q <= wcnt_q + 3'd1;
            end
          end
        end

        // Busy on entry means the TX is still occupied: hold off the request.
        StSend: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= sel_byte;
            state_q  <= StWaitAck;
          end
        end

        // Wait for the TX to pick up the byte before watching for idle again,
        // so a request is never repeated on a stale idle.
        StWaitAck: begin
          if (tx_busy) begin
            state_q <= StWaitIdle;
          end
        end

        StWaitIdle: begin
          if (!tx_busy) begin
            if (bidx_q == LastIdx) begin
              state_q <= StDone;
            end else begin
              bidx_q  <= bidx_q + 6'd1;
              state_q <= StSend;
            end
          end
        end

        StDone: begin
          digest_sent <= 1'b1;
          word_rdy    <= 1'b1;
          state_q     <= StLoad;
        end

        default: begin
          word_rdy <= 1'b1;
          state_q  <= StLoad;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_digest_serializer.sv
// Bench for m_digest_serializer: two instances (with and without terminator)
// share the word inputs; each has its own UART model. Expected bytes are
// queued when words are driven and popped when tx_start is observed.
module tb_m_digest_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_in;
  logic        word_vld;

  logic        word_rdy1, tx_busy1, tx_start1, digest_sent1, load_err1;
  logic [7:0]  tx_data1;
  logic        word_rdy0, tx_busy0, tx_start0, digest_sent0, load_err0;
  logic [7:0]  tx_data0;

  always #5 clk = ~clk;

  m_digest_serializer #(.SEND_TERM(1'b1), .TERM_BYTE(8'h0A)) u1 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_vld(word_vld), .word_rdy(word_rdy1),
    .tx_busy(tx_busy1), .tx_start(tx_start1), .tx_data(tx_data1),
    .digest_sent(digest_sent1), .load_err(load_err1)
  );

  m_digest_serializer #(.SEND_TERM(1'b0), .TERM_BYTE(8'h0A)) u0 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_vld(word_vld), .word_rdy(word_rdy0),
    .tx_busy(tx_busy0), .tx_start(tx_start0), .tx_data(tx_data0),
    .digest_sent(digest_sent0), .load_err(load_err0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART models: busy for 4 cycles after each start. The u1 model can insert
  // a 50-cycle busy stall one cycle after byte 4 completes, so u1 enters SEND
  // with busy already high.
  bit bp_en = 1'b0;
  int bc1, sc1, mc1, bc0;
  bit arm1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bc1 <= 0; sc1 <= 0; mc1 <= 0; arm1 <= 1'b0;
    end else begin
      if (digest_sent1) mc1 <= 0;
      if (sc1 != 0) sc1 <= sc1 - 1;
      if (tx_start1) begin
        bc1 <= 4;
        mc1 <= mc1 + 1;
        if (bp_en && mc1 == 4) arm1 <= 1'b1;
      end else if (bc1 != 0) begin
        bc1 <= bc1 - 1;
        if (bc1 == 1 && arm1) begin
          arm1 <= 1'b0;
          sc1  <= 51;
        end
      end
    end
  end
  assign tx_busy1 = (bc1 != 0) || (sc1 != 0 && sc1 <= 50);

  always @(posedge clk or negedge rst) begin
    if (!rst) bc0 <= 0;
    else if (tx_start0) bc0 <= 4;
    else if (bc0 != 0) bc0 <= bc0 - 1;
  end
  assign tx_busy0 = (bc0 != 0);

  // Scoreboard and protocol monitors.
  logic [7:0] q1[$], q0[$], log1[$], log0[$];
  int  n1 = 0, n0 = 0, ds1 = 0, ds0 = 0;
  bit  mon_en = 1'b0;
  bit  armed1, armed0, ps1, ps0, pd1, pd0;
  logic [7:0] last1;
  int  stall_cycles, stall_bad;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst) begin
        armed1 = 1'b1; ps1 = 1'b0; pd1 = 1'b0;
      end else begin
        if (sc1 != 0 && sc1 <= 50) begin
          stall_cycles++;
          if (tx_start1 || tx_data1 !== last1) stall_bad++;
        end
        if (tx_start1) begin
          chk("start_pulse_u1", {31'd0, ps1}, 32'd0);
          chk("handshake_u1", {31'd0, armed1}, 32'd1);
          armed1 = 1'b0;
          n1++;
          log1.push_back(tx_data1);
          last1 = tx_data1;
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_byte_u1: got %0h expected no byte", tx_data1);
          end else begin
            chk("byte_u1", {24'd0, tx_data1}, {24'd0, q1.pop_front()});
          end
        end
        if (tx_busy1) armed1 = 1'b1;
        if (digest_sent1) begin
          chk("digest_pulse_u1", {31'd0, pd1}, 32'd0);
          ds1++;
        end
        ps1 = tx_start1;
        pd1 = digest_sent1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst) begin
        armed0 = 1'b1; ps0 = 1'b0; pd0 = 1'b0;
      end else begin
        if (tx_start0) begin
          chk("start_pulse_u0", {31'd0, ps0}, 32'd0);
          chk("handshake_u0", {31'd0, armed0}, 32'd1);
          armed0 = 1'b0;
          n0++;
          log0.push_back(tx_data0);
          if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_byte_u0: got %0h expected no byte", tx_data0);
          end else begin
            chk("byte_u0", {24'd0, tx_data0}, {24'd0, q0.pop_front()});
          end
        end
        if (tx_busy0) armed0 = 1'b1;
        if (digest_sent0) begin
          chk("digest_pulse_u0", {31'd0, pd0}, 32'd0);
          ds0++;
        end
        ps0 = tx_start0;
        pd0 = digest_sent0;
      end
    end
  end

  typedef struct packed {
    logic [255:0] w;      // H0 in [255:224]
    bit           ovf;    // drive a 9th word right after the 8th
    bit           bp;     // 50-cycle busy stall before byte 5 (u1)
    bit           err;    // expected load_err after the run
    logic [7:0]   first;  // expected first byte
    logic [7:0]   last0;  // expected last byte without terminator
  } vec_t;

  vec_t tv [3];

  task automatic push_exp(input logic [255:0] w);
    logic [7:0] b;
    for (int i = 0; i < 32; i++) begin
      b = w[255 - 8*i -: 8];
      q1.push_back(b);
      q0.push_back(b);
    end
    q1.push_back(8'h0A);
  endtask

  task automatic load_words(input logic [255:0] w, input bit ovf);
    for (int i = 0; i < 8; i++) begin
      word_in  = w[255 - 32*i -: 32];
      word_vld = 1'b1;
      @(posedge clk); #1;
    end
    chk("rdy_low_after_8th_u1", {31'd0, word_rdy1}, 32'd0);
    if (ovf) begin
      word_in  = 32'hDEADBEEF;
      word_vld = 1'b1;
      @(posedge clk); #1;
    end
    word_vld = 1'b0;
    word_in  = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    int s1b, s0b, d1b, d0b, cyc;
    chk("rdy_before_u1", {31'd0, word_rdy1}, 32'd1);
    chk("rdy_before_u0", {31'd0, word_rdy0}, 32'd1);
    s1b = n1; s0b = n0; d1b = ds1; d0b = ds0;
    log1.delete(); log0.delete();
    bp_en = v.bp;
    stall_cycles = 0;
    stall_bad = 0;
    push_exp(v.w);
    load_words(v.w, v.ovf);
    cyc = 0;
    while ((ds1 == d1b || ds0 == d0b) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    chk("done_in_time", {31'd0, cyc < 3000}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bytes_u1", n1 - s1b, 33);
    chk("bytes_u0", n0 - s0b, 32);
    chk("digest_cnt_u1", ds1 - d1b, 1);
    chk("digest_cnt_u0", ds0 - d0b, 1);
    chk("pending_u1", q1.size(), 0);
    chk("pending_u0", q0.size(), 0);
    chk("first_u1", {24'd0, log1[0]}, {24'd0, v.first});
    chk("first_u0", {24'd0, log0[0]}, {24'd0, v.first});
    chk("term_u1", {24'd0, log1[32]}, 32'h0A);
    chk("last_u0", {24'd0, log0[31]}, {24'd0, v.last0});
    chk("rdy_after_u1", {31'd0, word_rdy1}, 32'd1);
    chk("rdy_after_u0", {31'd0, word_rdy0}, 32'd1);
    chk("load_err_u1", {31'd0, load_err1}, {31'd0, v.err});
    chk("load_err_u0", {31'd0, load_err0}, {31'd0, v.err});
    if (v.bp) begin
      chk("stall_cycles", stall_cycles, 50);
      chk("stall_quiet", stall_bad, 0);
    end
    q1.delete(); q0.delete();
    bp_en = 1'b0;
  endtask

  initial begin
    vec_t v;
    int cyc, nb;

    tv[0] = '{w: 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19,
              ovf: 1'b0, bp: 1'b0, err: 1'b0, first: 8'h6A, last0: 8'h19};
    tv[1] = '{w: 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19,
              ovf: 1'b0, bp: 1'b1, err: 1'b0, first: 8'h6A, last0: 8'h19};
    tv[2] = '{w: 256'h00112233_44556677_8899AABB_CCDDEEFF_01234567_89ABCDEF_FEDCBA98_76543210,
              ovf: 1'b1, bp: 1'b0, err: 1'b1, first: 8'h00, last0: 8'h10};

    rst = 1'b1;
    word_vld = 1'b0;
    word_in = 32'h0;

    // Reset asserted mid-cycle must take effect without a clock edge.
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("rst_rdy_u1", {31'd0, word_rdy1}, 32'd1);
    chk("rst_start_u1", {31'd0, tx_start1}, 32'd0);
    chk("rst_data_u1", {24'd0, tx_data1}, 32'd0);
    chk("rst_digest_u1", {31'd0, digest_sent1}, 32'd0);
    chk("rst_err_u1", {31'd0, load_err1}, 32'd0);
    chk("rst_rdy_u0", {31'd0, word_rdy0}, 32'd1);
    chk("rst_start_u0", {31'd0, tx_start0}, 32'd0);
    chk("rst_err_u0", {31'd0, load_err0}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 3; r++) begin
      run_vec(tv[r]);
    end

    // Reset while byte 10 is being requested: abort at once, then reload.
    push_exp(256'h11112222_33334444_55556666_77778888_9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000);
    nb = n1;
    load_words(256'h11112222_33334444_55556666_77778888_9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000,
               1'b0);
    cyc = 0;
    while (n1 < nb + 10 && cyc < 1000) begin
      @(negedge clk); #2;
      cyc++;
    end
    chk("reach_byte10", {31'd0, cyc < 1000}, 32'd1);
    chk("start_before_rst", {31'd0, tx_start1}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_start_u1", {31'd0, tx_start1}, 32'd0);
    chk("midrst_start_u0", {31'd0, tx_start0}, 32'd0);
    chk("midrst_rdy_u1", {31'd0, word_rdy1}, 32'd1);
    chk("midrst_data_u1", {24'd0, tx_data1}, 32'd0);
    chk("midrst_err_u1", {31'd0, load_err1}, 32'd0);
    q1.delete(); q0.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    nb = n1;
    repeat (30) @(posedge clk);
    #1;
    chk("no_bytes_after_rst", n1, nb);
    chk("idle_rdy_u1", {31'd0, word_rdy1}, 32'd1);

    v = '{w: 256'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_13579BDF_2468ACE0_DEADBEEF_CAFEF00D,
          ovf: 1'b0, bp: 1'b0, err: 1'b0, first: 8'h0F, last0: 8'h0D};
    run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
